// File: rtl/fb_pkg.sv
// fb_pkg: shared types, FSM state codes and sizing helpers for the frame-buffer pattern writer.
package fb_pkg;

    // Pattern selector encoding, matches the mode input.
    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_RECT    = 2'd1,
        MODE_HBARS   = 2'd2,
        MODE_CHECKER = 2'd3
    } fb_mode_e;

    // FSM state codes, kept as plain constants for compatibility with older blocks.
    typedef logic [1:0] fb_state_t;
    localparam fb_state_t ST_IDLE = 2'd0;
    localparam fb_state_t ST_FILL = 2'd1;
    localparam fb_state_t ST_EMIT = 2'd2;
    localparam fb_state_t ST_DONE = 2'd3;

    // Number of RAM words in one frame.
    function automatic int unsigned fb_words(input int unsigned h_active,
                                             input int unsigned v_active,
                                             input int unsigned word_w);
        return (h_active * v_active) / word_w;
    endfunction

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned fb_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_word_packer.sv
// fb_word_packer: collects one pixel per load into a WORD_W-bit word, bit 0 first.
module fb_word_packer
    import fb_pkg::*;
#(
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              pixel,
    output logic [WORD_W-1:0] data,
    output logic              full
);

    localparam int unsigned IDX_W = fb_width(WORD_W);

    logic [IDX_W-1:0] idx;

    // High on the load that completes the current word.
    assign full = load && (idx == IDX_W'(WORD_W - 1));

    // Store each pixel at its bit position; the index wraps once the word is complete.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data <= '0;
            idx  <= '0;
        end else if (load) begin
            data[idx] <= pixel;
            idx       <= full ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/fb_pattern_writer.sv
// fb_pattern_writer: walks an H_ACTIVE x V_ACTIVE 1-bpp frame, evaluates the selected pattern
// and writes packed words to the frame-buffer RAM over a valid/ready port.
// Optional feature: define FB_PATTERN_CHECKER_EN to enable the CHECKER pattern on mode 3;
// without it mode 3 produces the SOLID pattern.
module fb_pattern_writer
    import fb_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned BAR_LOG2  = 5,
    parameter int unsigned CELL_LOG2 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              fg,
    input  logic [10:0]       rect_x0,
    input  logic [10:0]       rect_x1,
    input  logic [9:0]        rect_y0,
    input  logic [9:0]        rect_y1,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned FB_WORDS = fb_words(H_ACTIVE, V_ACTIVE, WORD_W);
    localparam int unsigned X_W      = fb_width(H_ACTIVE);
    localparam int unsigned Y_W      = fb_width(V_ACTIVE);

    if (H_ACTIVE % WORD_W != 0) begin : g_bad_h_active
        $error("H_ACTIVE must be a multiple of WORD_W");
    end
    if ((64'd1 << ADDR_W) < 64'(FB_WORDS)) begin : g_bad_addr_w
        $error("ADDR_W too small for the frame");
    end
    // Pixel coordinates are evaluated in 16-bit space.
    if (X_W > 16 || Y_W > 16 || BAR_LOG2 > 15 || CELL_LOG2 > 15) begin : g_bad_coord
        $error("frame or pattern geometry exceeds 16-bit coordinate space");
    end

    fb_state_t        state_q, state_d;
    fb_mode_e         mode_q;
    logic             fg_q;
    logic [10:0]      x0_q, x1_q;
    logic [9:0]       y0_q, y1_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [ADDR_W-1:0] addr_q;

    logic        pix;
    logic        in_rect;
    logic        word_full;
    logic        last_word;
    logic        accept;
    logic [15:0] px, py;

    assign px        = 16'(x_q);
    assign py        = 16'(y_q);
    assign last_word = (addr_q == ADDR_W'(FB_WORDS - 1));
    assign accept    = (state_q == ST_EMIT) && wr_ready;

    // Half-open bounds; an empty or off-frame rectangle simply never matches.
    assign in_rect = (px >= {5'd0, x0_q}) && (px < {5'd0, x1_q}) &&
                     (py >= {6'd0, y0_q}) && (py < {6'd0, y1_q});

    // Pattern value for the pixel at (x_q, y_q) under the latched configuration.
    always_comb begin
        pix = fg_q;
        case (mode_q)
            MODE_SOLID: pix = fg_q;
            MODE_RECT:  pix = in_rect ? fg_q : ~fg_q;
            MODE_HBARS: pix = py[BAR_LOG2] ^ fg_q;
`ifdef FB_PATTERN_CHECKER_EN
            MODE_CHECKER: pix = px[CELL_LOG2] ^ py[CELL_LOG2] ^ fg_q;
`else
            MODE_CHECKER: pix = fg_q;
`endif
            default:    pix = fg_q;
        endcase
    end

    // Next-state logic: fill a word, hold it until accepted, repeat until the last word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_FILL;
            ST_FILL: if (word_full) state_d = ST_EMIT;
            ST_EMIT: if (wr_ready) state_d = last_word ? ST_DONE : ST_FILL;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration latch, pixel scan position and word address.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_SOLID;
            fg_q   <= 1'b0;
            x0_q   <= '0;
            x1_q   <= '0;
            y0_q   <= '0;
            y1_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= fb_mode_e'(mode);
                        fg_q   <= fg;
                        x0_q   <= rect_x0;
                        x1_q   <= rect_x1;
                        y0_q   <= rect_y0;
                        y1_q   <= rect_y1;
                        x_q    <= '0;
                        y_q    <= '0;
                        addr_q <= '0;
                    end
                end
                ST_FILL: begin
                    if (x_q == X_W'(H_ACTIVE - 1)) begin
                        x_q <= '0;
                        y_q <= y_q + Y_W'(1);
                    end else begin
                        x_q <= x_q + X_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (accept && !last_word) addr_q <= addr_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    fb_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk   (clk),
        .reset (reset),
        .clear ((state_q == ST_IDLE) && start),
        .load  (state_q == ST_FILL),
        .pixel (pix),
        .data  (wr_data),
        .full  (word_full)
    );

    assign wr_en   = (state_q == ST_EMIT);
    assign wr_addr = addr_q;
    assign busy    = (state_q == ST_FILL) || (state_q == ST_EMIT);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_fb_pattern_writer.sv
// tb_fb_pattern_writer: scoreboard bench; a frame model pushes expected words on each start and
// a negedge monitor pops and compares every accepted write.
module tb_fb_pattern_writer;

    localparam int unsigned H   = 64;
    localparam int unsigned V   = 20;
    localparam int unsigned W   = 16;
    localparam int unsigned AW  = 7;
    localparam int unsigned BL  = 2;
    localparam int unsigned CL  = 3;
    localparam int unsigned N   = H * V / W;
    localparam int unsigned WPL = H / W;
    localparam int          FRAME_BUDGET = 6000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          fg = 1'b0;
    logic [10:0]   rect_x0 = '0, rect_x1 = '0;
    logic [9:0]    rect_y0 = '0, rect_y1 = '0;
    logic          wr_en;
    logic          wr_ready = 1'b1;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          busy, done;

    fb_pattern_writer #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .WORD_W    (W),
        .ADDR_W    (AW),
        .BAR_LOG2  (BL),
        .CELL_LOG2 (CL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .fg       (fg),
        .rect_x0  (rect_x0),
        .rect_x1  (rect_x1),
        .rect_y0  (rect_y0),
        .rect_y1  (rect_y1),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    int stall_left = 0;
    int ready_mode = 0;

    logic [AW-1:0] q_addr[$];
    logic [W-1:0]  q_data[$];
    logic [W-1:0]  mem[N];

    bit            stalled = 1'b0;
    logic [AW-1:0] s_addr;
    logic [W-1:0]  s_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference pattern: one pixel straight from the pattern rules.
    function automatic logic model_pix(input int m, input logic f, input int x0, input int x1,
                                       input int y0, input int y1, input int x, input int y);
        logic b;
        case (m)
            0: b = f;
            1: b = (x >= x0 && x < x1 && y >= y0 && y < y1) ? f : !f;
            2: b = (((y >> BL) % 2) == 1) ^ f;
            default: begin
`ifdef FB_PATTERN_CHECKER_EN
                b = (((x >> CL) % 2) == 1) ^ (((y >> CL) % 2) == 1) ^ f;
`else
                b = f;
`endif
            end
        endcase
        return b;
    endfunction

    task automatic push_frame(input int m, input logic f, input int x0, input int x1,
                              input int y0, input int y1);
        logic [W-1:0] d;
        for (int i = 0; i < int'(N); i++) begin
            for (int b = 0; b < int'(W); b++) begin
                d[b] = model_pix(m, f, x0, x1, y0, y1, (i % WPL) * W + b, i / WPL);
            end
            q_addr.push_back(AW'(i));
            q_data.push_back(d);
        end
    endtask

    // Monitor: compares every accepted write, checks hold-while-stalled and done pulses.
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_wr_en_held", 64'(wr_en), 64'd1);
                chk("stall_addr_stable", 64'(wr_addr), 64'(s_addr));
                chk("stall_data_stable", 64'(wr_data), 64'(s_data));
            end
            if (wr_en && !wr_ready) begin
                stalled = 1'b1;
                s_addr  = wr_addr;
                s_data  = wr_data;
                stall_cnt++;
            end else begin
                stalled = 1'b0;
            end
            if (wr_en && wr_ready) begin
                if (q_addr.size() == 0) begin
                    chk("unexpected_write", 64'(wr_addr), 64'hFFFF_FFFF);
                end else begin
                    chk("write_addr", 64'(wr_addr), 64'(q_addr.pop_front()));
                    chk("write_data", 64'(wr_data), 64'(q_data.pop_front()));
                end
                if (wr_addr < AW'(N)) mem[wr_addr] = wr_data;
            end
            if (done) begin
                done_cnt++;
                chk("done_with_words_pending", 64'(q_addr.size()), 64'd0);
            end
        end
    end

    // Write-ready driver: always high, random, or a single 10-cycle stall on word 5.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            wr_ready = ($urandom_range(0, 3) != 0);
        end else if (stall_left > 0 && wr_en && wr_addr == AW'(5)) begin
            wr_ready = 1'b0;
            stall_left--;
        end else begin
            wr_ready = 1'b1;
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // Called at #1 after an edge; reset is sampled on the next edge.
    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q_addr.delete();
        q_data.delete();
        chk_idle("after_reset");
    endtask

    task automatic start_frame(input int m, input logic f, input int x0, input int x1,
                               input int y0, input int y1, output int k);
        @(posedge clk);
        #1;
        mode    = 2'(m);
        fg      = f;
        rect_x0 = 11'(x0);
        rect_x1 = 11'(x1);
        rect_y0 = 10'(y0);
        rect_y1 = 10'(y1);
        start   = 1'b1;
        push_frame(m, f, x0, x1, y0, y1);
        @(posedge clk);
        #1;
        k     = cyc;
        start = 1'b0;
        // Scramble configuration; the latched copy must be used.
        mode    = 2'($urandom);
        fg      = 1'($urandom);
        rect_x0 = 11'($urandom);
        rect_x1 = 11'($urandom);
        rect_y0 = 10'($urandom);
        rect_y1 = 10'($urandom);
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("wr_en_after_start", 64'(wr_en), 64'd0);
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_addr(input int a, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (wr_en && wr_addr == AW'(a)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) chk("wait_addr_timeout", 64'(a), 64'hFFFF_FFFF);
    endtask

    task automatic run_frame(input int m, input logic f, input int x0, input int x1,
                             input int y0, input int y1, input bit exact);
        int k, at, dc;
        dc = done_cnt;
        start_frame(m, f, x0, x1, y0, y1, k);
        if (exact) begin
            repeat (W - 1) @(posedge clk);
            #1;
            chk("wr_en_before_first_word", 64'(wr_en), 64'd0);
            @(posedge clk);
            #1;
            chk("wr_en_first_word", 64'(wr_en), 64'd1);
            chk("first_word_addr", 64'(wr_addr), 64'd0);
        end
        wait_done(FRAME_BUDGET, at);
        if (at >= 0) begin
            if (exact) chk("frame_cycles", 64'(at - k), 64'(N * (W + 1)));
            @(posedge clk);
            #1;
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("busy_after_done", 64'(busy), 64'd0);
            chk("done_count", 64'(done_cnt - dc), 64'd1);
            chk("all_words_written", 64'(q_addr.size()), 64'd0);
        end else begin
            do_reset();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, dc;
        logic [W-1:0] exp_c0, exp_c8;

        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 1'b0;

        // Partial frame interrupted by reset, then a full SOLID frame with exact timing.
        start_frame(0, 1'b0, 0, 0, 0, 0, k);
        wait_addr(10, FRAME_BUDGET);
        do_reset();
        run_frame(0, 1'b1, 0, 0, 0, 0, 1'b1);
        chk("solid_first", 64'(mem[0]), 64'hFFFF);
        chk("solid_last", 64'(mem[N-1]), 64'hFFFF);

        // Single-row rectangle spanning exactly word 1.
        run_frame(1, 1'b1, 16, 32, 0, 1, 1'b1);
        chk("rect_addr0", 64'(mem[0]), 64'h0000);
        chk("rect_addr1", 64'(mem[1]), 64'hFFFF);
        chk("rect_addr2", 64'(mem[2]), 64'h0000);
        chk("rect_next_row", 64'(mem[WPL]), 64'h0000);

        // Empty rectangle.
        run_frame(1, 1'b1, 10, 10, 0, 20, 1'b1);
        chk("empty_rect_first", 64'(mem[0]), 64'h0000);
        chk("empty_rect_last", 64'(mem[N-1]), 64'h0000);

        // Checker (or SOLID fallback) with fg=0.
`ifdef FB_PATTERN_CHECKER_EN
        exp_c0 = 16'hFF00;
        exp_c8 = 16'h00FF;
`else
        exp_c0 = 16'h0000;
        exp_c8 = 16'h0000;
`endif
        run_frame(3, 1'b0, 0, 0, 0, 0, 1'b1);
        chk("checker_addr0", 64'(mem[0]), 64'(exp_c0));
        chk("checker_row8", 64'(mem[8*WPL]), 64'(exp_c8));

        // Horizontal bars.
        run_frame(2, 1'b1, 0, 0, 0, 0, 1'b1);
        chk("hbars_row0", 64'(mem[0]), 64'hFFFF);
        chk("hbars_row4", 64'(mem[4*WPL]), 64'h0000);

        // Ten-cycle stall on word 5.
        stall_cnt  = 0;
        stall_left = 10;
        run_frame(1, 1'b0, 5, 70, 2, 9, 1'b0);
        chk("stall_cycles", 64'(stall_cnt), 64'd10);

        // Start while busy is ignored; reset mid-frame leaves no done pulse.
        start_frame(2, 1'b0, 0, 0, 0, 0, k);
        repeat (7) @(posedge clk);
        #1;
        mode  = 2'd0;
        fg    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_addr(40, FRAME_BUDGET);
        dc = done_cnt;
        do_reset();
        repeat (30) @(posedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_cnt - dc), 64'd0);
        chk("idle_wr_en_after_reset", 64'(wr_en), 64'd0);
        chk("idle_busy_after_reset", 64'(busy), 64'd0);

        // Reset and start together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_beats_start_busy", 64'(busy), 64'd0);
        chk("reset_beats_start_wr_en", 64'(wr_en), 64'd0);

        // Random configurations with random back-pressure.
        ready_mode = 1;
        for (int r = 0; r < 5; r++) begin
            run_frame(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 80)),
                      int'($urandom_range(0, 80)), int'($urandom_range(0, 30)),
                      int'($urandom_range(0, 30)), 1'b0);
        end
        ready_mode = 0;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
